cc_sidemonitor: RTL
===================

# cc_sidemonitor

Registered, parametrised successor to the lane-edge comparator in the road-game datapath. It samples the player-row bus on a game-tick strobe and flags left-edge and right-edge contact. It debounces contact over a configurable number of consecutive ticks and latches a sticky side-crash flag until the game controller clears it. It sits between the player-position register and the game-control FSM.

## Interface
- SIDEMONITOR_DATAWIDTH, default 8: width of the row bus; must be ≥ 1.
- SIDEMONITOR_HOLD, default 3: consecutive hit samples that trigger a crash; valid range 1 .. 2^SIDEMONITOR_CNTWIDTH − 1.
- SIDEMONITOR_CNTWIDTH, default 4: width of the contact counter.
- SIDEMONITOR_MODE, default 0: hit rule. 0 = exact one-hot at an edge. 1 = any overlap with an edge bit.

Ports (name, direction, width, meaning):
- CC_SIDEMONITOR_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- CC_SIDEMONITOR_RESET_InHigh  in  1  synchronous, active-high reset.
- CC_SIDEMONITOR_sample_InHigh  in  1  game-tick strobe; bus is evaluated only when high.
- CC_SIDEMONITOR_clear_InHigh  in  1  clears the crash latch and the counter.
- CC_SIDEMONITOR_data_InBUS  in  DATAWIDTH  player row pattern.
- CC_SIDEMONITOR_left_OutLow  out  1  low when the last sample touched the MSB edge.
- CC_SIDEMONITOR_right_OutLow  out  1  low when the last sample touched the LSB edge.
- CC_SIDEMONITOR_side_OutLow  out  1  low while crash is latched.
- CC_SIDEMONITOR_crash_OutHigh  out  1  one-cycle pulse on crash entry.
- CC_SIDEMONITOR_count_OutBUS  out  CNTWIDTH  current consecutive-hit count.

## Operation
- Edge hits per MODE:
  - MODE 0: leftHit = (data == 1<<(W−1)); rightHit = (data == 1).
  - MODE 1: leftHit = data[W−1]; rightHit = data[0].
  - hit = leftHit | rightHit.
  - W = 1: both hits are true together whenever data = 1.
- FSM states: IDLE, CONTACT, CRASH. Reset state is IDLE.
- Clear has priority: clear high in any state → IDLE, count = 0. Any sample that cycle is ignored for the FSM, but left/right still update.
- IDLE:
  - sample & hit → count = 1.
  - Go to CRASH if HOLD == 1, else go to CONTACT.
  - sample & !hit → stay in IDLE.
- CONTACT:
  - sample & hit → count + 1.
  - Go to CRASH when count + 1 == HOLD, else stay in CONTACT.
  - sample & !hit → IDLE, count = 0.
- CRASH:
  - Ignores samples for state and count.
  - count holds at HOLD.
  - Exits only on clear or reset.
- left_OutLow = !leftHit and right_OutLow = !rightHit, registered on every sample (all states). Both hold between samples.
- side_OutLow = 0 exactly while state == CRASH.
- crash_OutHigh = 1 for the single cycle following the edge that enters CRASH.
- Between strobes, all state and outputs hold.

## Timing
- Reset values: left_OutLow = 1, right_OutLow = 1, side_OutLow = 1, crash_OutHigh = 0, count = 0, state IDLE.
- Reset mid-operation, including in CRASH, returns everything to the reset values on the next edge.
- Latency: sample at edge k → left/right/count/state visible after edge k (1 cycle).
  - The HOLD-th consecutive hit sample sets side_OutLow = 0 and crash_OutHigh = 1 after the same edge.
- Back-to-back strobes (sample held high) are legal; each cycle counts as one sample.
- Clear and a hit sample in the same cycle: state = IDLE, count = 0, left/right reflect that sample.
- Clear while in IDLE: no effect besides count = 0.
- The counter never wraps; its maximum value is HOLD.

## Test plan
All scenarios use W = 4, HOLD = 3, MODE 0 unless noted.
- Reset: assert reset for 2 cycles with data = 4'b1000 and sample = 1 → all outputs at reset values, count = 0.
- Left debounce: samples 1000, 1000, 1000 → count 1, 2, 3. After the third edge: left = 0, side = 0, crash pulse exactly 1 cycle. Further samples leave count at 3 and side at 0.
- Broken contact: samples 0001, 0001, 0100, 0001 → count 1, 2, 0, 1. Right toggles 0, 0, 1, 0. No crash.
- Mode difference: data = 1001 and 1100, 3 samples each. MODE 0 gives no hits, count stays 0. MODE 1 gives 1001 → left = 0, right = 0, crash after the 3rd sample.
- Clear priority: in CRASH, assert clear together with a sample of 1000 → next cycle: IDLE, side = 1, count = 0, left = 0. The next sample of 1000 gives count = 1.
- Strobe gating: data = 0001 with sample low for 10 cycles → no output change. HOLD = 1 build: a single sample gives crash on the first edge.

Source files
------------

// File: rtl/cc_sidemonitor.sv
// cc_sidemonitor: samples the player row on each game tick, flags edge contact,
// debounces it over HOLD ticks and latches a sticky side-crash until cleared.
module cc_sidemonitor #(
  parameter int SIDEMONITOR_DATAWIDTH = 8,
  parameter int SIDEMONITOR_HOLD      = 3,
  parameter int SIDEMONITOR_CNTWIDTH  = 4,
  parameter int SIDEMONITOR_MODE      = 0
) (
  input  logic                            CC_SIDEMONITOR_CLOCK_50,
  input  logic                            CC_SIDEMONITOR_RESET_InHigh,
  input  logic                            CC_SIDEMONITOR_sample_InHigh,
  input  logic                            CC_SIDEMONITOR_clear_InHigh,
  input  logic [SIDEMONITOR_DATAWIDTH-1:0] CC_SIDEMONITOR_data_InBUS,
  output logic                            CC_SIDEMONITOR_left_OutLow,
  output logic                            CC_SIDEMONITOR_right_OutLow,
  output logic                            CC_SIDEMONITOR_side_OutLow,
  output logic                            CC_SIDEMONITOR_crash_OutHigh,
  output logic [SIDEMONITOR_CNTWIDTH-1:0]  CC_SIDEMONITOR_count_OutBUS
);

  localparam int DW = SIDEMONITOR_DATAWIDTH;
  localparam int CW = SIDEMONITOR_CNTWIDTH;

  localparam logic [DW-1:0] leftOnly  = DW'(1) << (DW - 1);
  localparam logic [DW-1:0] rightOnly = DW'(1);
  localparam logic [CW-1:0] holdVal   = CW'(SIDEMONITOR_HOLD);
  localparam logic [CW-1:0] oneVal    = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    CONTACT,
    CRASH
  } state_t;

  state_t state;
  logic leftHit;
  logic rightHit;
  logic hit;
  logic [CW-1:0] countInc;

  always_comb begin
    leftHit  = 1'b0;
    rightHit = 1'b0;
    if (SIDEMONITOR_MODE == 0) begin
      leftHit  = (CC_SIDEMONITOR_data_InBUS == leftOnly);
      rightHit = (CC_SIDEMONITOR_data_InBUS == rightOnly);
    end else begin
      leftHit  = CC_SIDEMONITOR_data_InBUS[DW-1];
      rightHit = CC_SIDEMONITOR_data_InBUS[0];
    end
  end

  assign hit      = leftHit | rightHit;
  assign countInc = CC_SIDEMONITOR_count_OutBUS + oneVal;

  always_ff @(posedge CC_SIDEMONITOR_CLOCK_50) begin
    if (CC_SIDEMONITOR_RESET_InHigh) begin
      state                        <= IDLE;
      CC_SIDEMONITOR_count_OutBUS  <= '0;
      CC_SIDEMONITOR_left_OutLow   <= 1'b1;
      CC_SIDEMONITOR_right_OutLow  <= 1'b1;
      CC_SIDEMONITOR_side_OutLow   <= 1'b1;
      CC_SIDEMONITOR_crash_OutHigh <= 1'b0;
    end else begin
      CC_SIDEMONITOR_crash_OutHigh <= 1'b0;
      // edge flags track every sample, even while cleared or crashed
      if (CC_SIDEMONITOR_sample_InHigh) begin
        CC_SIDEMONITOR_left_OutLow  <= ~leftHit;
        CC_SIDEMONITOR_right_OutLow <= ~rightHit;
      end
      if (CC_SIDEMONITOR_clear_InHigh) begin
        state                       <= IDLE;
        CC_SIDEMONITOR_count_OutBUS <= '0;
        CC_SIDEMONITOR_side_OutLow  <= 1'b1;
      end else if (CC_SIDEMONITOR_sample_InHigh) begin
        unique case (state)
          IDLE: begin
            if (hit) begin
              CC_SIDEMONITOR_count_OutBUS <= oneVal;
              if (oneVal == holdVal) begin
                state                        <= CRASH;
                CC_SIDEMONITOR_side_OutLow   <= 1'b0;
                CC_SIDEMONITOR_crash_OutHigh <= 1'b1;
              end else begin
                state <= CONTACT;
              end
            end
          end
          CONTACT: begin
            if (hit) begin
              CC_SIDEMONITOR_count_OutBUS <= countInc;
              if (countInc == holdVal) begin
                state                        <= CRASH;
                CC_SIDEMONITOR_side_OutLow   <= 1'b0;
                CC_SIDEMONITOR_crash_OutHigh <= 1'b1;
              end
            end else begin
              state                       <= IDLE;
              CC_SIDEMONITOR_count_OutBUS <= '0;
            end
          end
          CRASH: begin
            state <= CRASH;
          end
          default: begin
            state                       <= IDLE;
            CC_SIDEMONITOR_count_OutBUS <= '0;
            CC_SIDEMONITOR_side_OutLow  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
